// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
// Purpose: state encoding, data width and default constants used by the fetch unit,
//          its interface and the next-PC selector.
// Ports:   none (package)
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_ADDR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR  = 32'h0000_0013;  // addi x0,x0,0

  // REQ: request presented to imem, WAIT: one fetch in flight,
  // HOLD: instruction presented to decode until consumed.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - branch-decision, imem and decode handshake bundle
// Purpose: groups every non-clock/reset signal of the fetch unit.
// Ports (modport master = fetch unit side):
//   in : pc_src, target_addr, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
//   out: imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, misaligned_err
// modport slave is the mirror image (execute, memory and decode side).
interface pc_fetch_unit_if;
  import fetch_pkg::*;

  logic            pc_src;
  logic [XLEN-1:0] target_addr;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            misaligned_err;

  modport master (
    input  pc_src, target_addr, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, misaligned_err
  );

  modport slave (
    output pc_src, target_addr, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, misaligned_err
  );

endinterface

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// rtl/pc_fetch_unit_pc_next_sel.sv - combinational next program-counter selector
// Purpose: picks the next PC with priority redirect target > pc+4 > hold.
// Ports:
//   i_pc          current PC
//   i_pc_src      redirect request from execute
//   i_target_addr redirect target (low two bits are dropped)
//   i_advance     current instruction consumed by decode
//   o_pc_next     PC to load on the next clock
//   o_misaligned  redirect target was not word aligned
module pc_next_sel
  import fetch_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_pc_src,
  input  logic [XLEN-1:0] i_target_addr,
  input  logic            i_advance,
  output logic [XLEN-1:0] o_pc_next,
  output logic            o_misaligned
);

  always_comb begin
    o_pc_next = i_pc;
    if (i_pc_src) begin
      o_pc_next = {i_target_addr[XLEN-1:2], 2'b00};
    end else if (i_advance) begin
      o_pc_next = i_pc + XLEN'(4);  // wraps modulo 2^32
    end
  end

  assign o_misaligned = i_pc_src && (i_target_addr[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter owner and single-outstanding instruction fetcher
// Purpose: issues one imem fetch at a time from the PC, hands the result to decode with
//          its PC, and squashes fetches made stale by a taken redirect.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pc_fetch_unit_if.master (redirect in, imem request/response, decode out)
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = DEFAULT_RESET_ADDR,
  parameter logic [XLEN-1:0] NOP_INSTR  = DEFAULT_NOP_INSTR
)
(
  input  logic              clk,
  input  logic              rst_n,
  pc_fetch_unit_if.master   bus
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic            r_kill;
  logic            w_kill_nxt;
  logic            w_capture;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            r_misaligned;
  logic            w_misaligned;
  logic            w_advance;

  assign w_advance = (r_state == ST_HOLD) && bus.instr_ready;

  pc_next_sel u_pc_next_sel (
    .i_pc          (r_pc),
    .i_pc_src      (bus.pc_src),
    .i_target_addr (bus.target_addr),
    .i_advance     (w_advance),
    .o_pc_next     (w_pc_nxt),
    .o_misaligned  (w_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_REQ;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_kill  <= w_kill_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_kill_nxt  = r_kill;
    w_capture   = 1'b0;
    case (r_state)
      ST_REQ: begin
        // A redirect that coincides with the handshake cannot retract the
        // request already sent, so its response is marked for dropping.
        if (bus.imem_req_ready) begin
          w_state_nxt = ST_WAIT;
          w_kill_nxt  = bus.pc_src;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (r_kill || bus.pc_src) begin
            w_state_nxt = ST_REQ;
            w_kill_nxt  = 1'b0;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end else if (bus.pc_src) begin
          w_kill_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.pc_src || bus.instr_ready) begin
          w_state_nxt = ST_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_REQ;
        w_kill_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_ADDR;
      r_instr      <= NOP_INSTR;
      r_instr_pc   <= RESET_ADDR;
      r_misaligned <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_misaligned <= w_misaligned;
      if (w_capture) begin
        r_instr    <= bus.imem_rsp_data;
        r_instr_pc <= r_pc;
      end
    end
  end

  // Gating with rst_n keeps the request low while reset is held even though
  // the state register already sits in REQ.
  assign bus.imem_req_valid = (r_state == ST_REQ) && rst_n;
  assign bus.imem_req_addr  = r_pc;
  assign bus.instr_valid    = (r_state == ST_HOLD);
  assign bus.instr          = (r_state == ST_HOLD) ? r_instr : NOP_INSTR;
  assign bus.instr_pc       = r_instr_pc;
  assign bus.misaligned_err = r_misaligned;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pc_fetch_unit_if bus();

  pc_fetch_unit #(.RESET_ADDR(RST_ADDR), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // reference model: architectural PC plus a one-deep memory
  logic [31:0] model_pc;
  logic        exp_mis;
  logic        pending;
  logic [31:0] pend_addr;
  int          lat_cnt;
  logic        hold_prev;
  logic [31:0] prev_instr, prev_pc;
  int          cyc;
  int          last_deliv_cyc;
  int          n_deliv;
  int          p_redir, p_mem, p_dec, max_lat;
  logic        check_spacing;

  task automatic model_reset();
    model_pc       = RST_ADDR;
    exp_mis        = 1'b0;
    pending        = 1'b0;
    pend_addr      = '0;
    lat_cnt        = 0;
    hold_prev      = 1'b0;
    last_deliv_cyc = -1;
  endtask

  task automatic step();
    logic [31:0] tgt;
    logic        deliv;
    @(negedge clk);
    cyc++;
    check("misaligned_err", {31'b0, bus.misaligned_err}, {31'b0, exp_mis});
    if (hold_prev) begin
      check("hold_valid", {31'b0, bus.instr_valid}, 32'd1);
      check("hold_instr", bus.instr, prev_instr);
      check("hold_pc", bus.instr_pc, prev_pc);
    end
    if (!bus.instr_valid) check("idle_nop", bus.instr, NOP);
    else                  check("instr_data", bus.instr, mem_word(bus.instr_pc));

    bus.pc_src = ($urandom_range(0, 99) < p_redir);
    case ($urandom_range(0, 4))
      0:       tgt = 32'h0000_0106;
      1:       tgt = 32'hFFFF_FFFC;
      2:       tgt = 32'hFFFF_FFF8;
      3:       tgt = $urandom & 32'h0000_0FFC;
      default: tgt = $urandom;
    endcase
    bus.target_addr    = tgt;
    bus.imem_req_ready = ($urandom_range(0, 99) < p_mem);
    bus.instr_ready    = ($urandom_range(0, 99) < p_dec);

    if (pending && lat_cnt == 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend_addr);
      pending            = 1'b0;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
      if (pending) lat_cnt--;
    end

    if (bus.imem_req_valid && bus.imem_req_ready) begin
      check("one_outstanding", {31'b0, pending}, 32'd0);
      check("req_addr", bus.imem_req_addr, model_pc);
      pending   = 1'b1;
      pend_addr = bus.imem_req_addr;
      lat_cnt   = $urandom_range(0, max_lat);
    end

    deliv = bus.instr_valid && bus.instr_ready && !bus.pc_src;
    if (deliv) begin
      check("deliver_pc", bus.instr_pc, model_pc);
      if (check_spacing && last_deliv_cyc >= 0) check("spacing", cyc - last_deliv_cyc, 32'd3);
      last_deliv_cyc = cyc;
      n_deliv++;
      model_pc = model_pc + 32'd4;
    end
    hold_prev  = bus.instr_valid && !bus.instr_ready && !bus.pc_src;
    prev_instr = bus.instr;
    prev_pc    = bus.instr_pc;

    if (bus.pc_src) begin
      model_pc = {tgt[31:2], 2'b00};
      exp_mis  = (tgt[1:0] != 2'b00);
    end else begin
      exp_mis = 1'b0;
    end
  endtask

  task automatic quiet_inputs();
    bus.pc_src         = 1'b0;
    bus.target_addr    = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.instr_ready    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, {31'b0, bus.imem_req_valid}, 32'd0);
    check({tag, "_instr_valid"}, {31'b0, bus.instr_valid}, 32'd0);
    check({tag, "_instr"}, bus.instr, NOP);
    check({tag, "_instr_pc"}, bus.instr_pc, RST_ADDR);
    check({tag, "_mis"}, {31'b0, bus.misaligned_err}, 32'd0);
  endtask

  task automatic release_reset();
    quiet_inputs();
    rst_n = 1'b1;
    model_reset();
    #1;
    check("rel_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    check("rel_req_addr", bus.imem_req_addr, RST_ADDR);
  endtask

  initial begin
    int  bound;
    logic found;
    cyc = 0;
    n_deliv = 0;
    check_spacing = 1'b0;
    quiet_inputs();
    model_reset();

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    release_reset();

    // zero-wait memory, decode always ready: one instruction per 3 cycles
    p_redir = 0; p_mem = 100; p_dec = 100; max_lat = 0;
    check_spacing = 1'b1;
    repeat (15) step();
    check_spacing = 1'b0;

    p_redir = 8; p_mem = 60; p_dec = 50; max_lat = 3;
    repeat (3000) step();

    // assert reset while a fetch is in flight
    p_redir = 0;
    found = 1'b0;
    bound = 0;
    while (!found && bound < 200) begin
      step();
      bound++;
      if (pending && lat_cnt > 0) found = 1'b1;
    end
    check("reach_wait", {31'b0, found}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    repeat (3) begin
      @(negedge clk);
      bus.imem_rsp_valid = ~bus.imem_rsp_valid;
      bus.imem_rsp_data  = $urandom;
    end
    check_reset_outputs("inrst");
    @(negedge clk);
    release_reset();

    p_redir = 8; p_mem = 70; p_dec = 60; max_lat = 2;
    repeat (1000) step();

    check("progress", {31'b0, (n_deliv > 100)}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumer end of the branch-decision interface in the unpipelined RISC-V core.
- Owns the program-counter register and takes the one-bit PC_src redirect decision plus the branch/jump target from execute.
- Issues one instruction-memory fetch at a time over a valid/ready request and valid response handshake.
- Hands each fetched instruction to decode with its PC, and squashes any fetch made stale by a taken redirect.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instr value presented while no valid instruction (addi x0,x0,0)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
pc_src  input  1  1 = redirect to target_addr this cycle (taken branch/jump)
target_addr  input  32  redirect target from execute
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  fetch address (word aligned)
imem_rsp_valid  input  1  fetch data returned (exactly one per accepted request)
imem_rsp_data  input  32  fetched instruction word
instr_valid  output  1  instr/instr_pc valid to decode
instr_ready  input  1  decode consumes instruction
instr  output  32  instruction to decode
instr_pc  output  32  PC of instr
misaligned_err  output  1  one-cycle pulse: redirect target had target_addr[1:0]!=0

Behaviour:
- Reset (async assert, sync deassert):
  - state=REQ; pc=RESET_ADDR; kill=0.
  - imem_req_valid=0 while in reset.
  - instr_valid=0; instr=NOP_INSTR; instr_pc=RESET_ADDR; misaligned_err=0.
- States: REQ, WAIT, HOLD. At most one outstanding fetch.
- REQ:
  - imem_req_valid=1; imem_req_addr=pc.
  - imem_req_valid first rises in the first clk after rst_n deasserts.
  - On imem_req_ready=1 -> WAIT.
  - The address is not required to be stable while ready=0; the memory samples it only on handshake.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid with kill=0: capture instr=imem_rsp_data and instr_pc=pc; set instr_valid=1 next cycle; -> HOLD.
  - On imem_rsp_valid with kill=1: drop the data; clear kill; -> REQ.
- HOLD:
  - instr_valid=1; instr and instr_pc held stable until instr_ready=1.
  - On instr_ready: pc<=pc+4; instr_valid<=0; -> REQ.
- Redirect (pc_src=1), highest priority in every state:
  - pc<=target_addr & ~32'h3.
  - REQ, ready=0: stay in REQ; the next cycle presents the new address.
  - REQ, ready=1: the handshake completes with the old address; -> WAIT with kill=1.
  - WAIT: set kill=1; if imem_rsp_valid arrives in the same cycle, drop it and -> REQ with kill=0.
  - HOLD: instr_valid<=0; -> REQ. If instr_ready is high in the same cycle, the target wins over pc+4.
  - Repeated redirects: the last target wins. kill stays a single bit, since only one fetch can be in flight.
- misaligned_err pulses in the cycle after any redirect with target_addr[1:0]!=0. The fetch proceeds at the aligned address.
- PC arithmetic is 32-bit modulo 2^32: pc+4 from 32'hFFFF_FFFC wraps to 0.
- Best-case throughput is one instruction per 3 cycles with a 0-wait memory (REQ, WAIT, HOLD).
- A reset mid-fetch abandons the in-flight fetch. Memory must also be reset; any response arriving during reset is ignored.

Decomposition:
- Shared package fetch_pkg: state encoding (REQ/WAIT/HOLD), NOP_INSTR, default RESET_ADDR, XLEN=32.
- One natural sub-module, pc_next_sel (combinational):
  - Inputs: pc, pc_src, target_addr, advance.
  - Outputs: next pc, misaligned flag.
  - Priority: target > pc+4 > hold.

Test Plan:
- Reset release, 0-wait memory, instr_ready=1 -> requests at 0x0, 0x4, 0x8; each instr_valid 3 cycles apart; instr_pc matches the request address.
- HOLD with instr_ready=0 for 5 cycles -> instr and instr_pc stable; no new imem_req_valid; pc advances only after ready.
- pc_src=1, target_addr=0x100 while in WAIT (response 2 cycles later) -> that response is dropped with no instr_valid; next request addr=0x100.
- pc_src=1 and instr_ready=1 in the same HOLD cycle, target 0x40 -> next imem_req_addr=0x40, not pc+4.
- target_addr=0x0000_0106 -> misaligned_err pulses once; fetch at 0x104.
- pc=0xFFFF_FFFC accepted -> next request address 0x0000_0000; async rst_n assert in WAIT -> outputs at reset values immediately, fetch restarts at RESET_ADDR.
